mcp_hv_ramp_ctrl: RTL and testbench



---
 rtl/mcp_hv_ramp_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mcp_hv_ramp_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp_hv_ramp_ctrl.sv
// rtl/mcp_hv_ramp_ctrl.sv - MCP HVPS DAC ramp sequencer
//
// Walks the 12-bit HV DAC code from 0 toward a programmable target. Each step
// is one DAC write followed by a fixed dwell. The block ramps back down when
// safe_cmd is asserted or hven_cmd is dropped, and writes 0 immediately when
// reset_cmd is asserted. It also owns the HVPS enable.
//
// Ports
//   clk50        : 50 MHz system clock
//   rst_n        : asynchronous active-low reset
//   hven_cmd     : level, request HV on
//   safe_cmd     : level, force ramp-down to 0
//   reset_cmd    : level, abort straight to code 0
//   target[11:0] : requested final DAC code
//   dac_busy     : DAC is shifting, no write may be issued
//   dac_set[11:0]: code presented to the DAC, valid with dac_pulse
//   dac_pulse    : one-cycle DAC write strobe
//   hven         : HVPS enable
//   at_target    : ramp settled (HOLD)
//   ramp_active  : stepping or aborting (WRITE, DWELL, ABORT)
module mcp_hv_ramp_ctrl #(
    parameter int STEP         = 230,
    parameter int START_CODE   = 10,
    parameter int DWELL_CYCLES = 20_000_000
) (
    input  logic        clk50,
    input  logic        rst_n,
    input  logic        hven_cmd,
    input  logic        safe_cmd,
    input  logic        reset_cmd,
    input  logic [11:0] target,
    input  logic        dac_busy,
    output logic [11:0] dac_set,
    output logic        dac_pulse,
    output logic        hven,
    output logic        at_target,
    output logic        ramp_active
);

    localparam logic [12:0] STEP13     = 13'(STEP);
    localparam logic [11:0] START12    = 12'(START_CODE);
    localparam logic [24:0] DWELL_LAST = 25'(DWELL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_DWELL,
        S_HOLD,
        S_ABORT
    } state_t;

    state_t      state_q;
    logic [11:0] cur_q;
    logic [11:0] nxt_q;
    logic [24:0] cnt_q;
    // Set once hven_cmd has been seen low after rst_n, so a level left high
    // across a reset does not start a ramp by itself.
    logic        armed_q;

    logic [11:0] eff_tgt;
    logic [11:0] step_d;
    logic [12:0] diff;

    assign eff_tgt = (safe_cmd || !hven_cmd) ? 12'd0 : target;

    // One step from cur_q toward eff_tgt, clipped so it never overshoots.
    // Evaluated in 13 bits so the distance comparison cannot wrap.
    always_comb begin
        diff   = 13'd0;
        step_d = cur_q;
        if (eff_tgt > cur_q) begin
            diff   = {1'b0, eff_tgt} - {1'b0, cur_q};
            step_d = (diff <= STEP13) ? eff_tgt : 12'({1'b0, cur_q} + STEP13);
        end else if (eff_tgt < cur_q) begin
            diff   = {1'b0, cur_q} - {1'b0, eff_tgt};
            step_d = (diff <= STEP13) ? eff_tgt : 12'({1'b0, cur_q} - STEP13);
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_q       <= 12'd0;
            nxt_q       <= 12'd0;
            cnt_q       <= 25'd0;
            armed_q     <= 1'b0;
            dac_set     <= 12'd0;
            dac_pulse   <= 1'b0;
            hven        <= 1'b0;
            at_target   <= 1'b0;
            ramp_active <= 1'b0;
        end else begin
            dac_pulse <= 1'b0;
            if (!hven_cmd) begin
                armed_q <= 1'b1;
            end

            if (reset_cmd && state_q != S_IDLE && state_q != S_ABORT) begin
                // Any dwell in progress is dropped.
                state_q     <= S_ABORT;
                cnt_q       <= 25'd0;
                at_target   <= 1'b0;
                ramp_active <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (armed_q && hven_cmd && !safe_cmd && !reset_cmd) begin
                            hven        <= 1'b1;
                            nxt_q       <= (target < START12) ? target : START12;
                            state_q     <= S_WRITE;
                            ramp_active <= 1'b1;
                        end
                    end
                    S_WRITE: begin
                        if (!dac_busy) begin
                            dac_set   <= nxt_q;
                            cur_q     <= nxt_q;
                            dac_pulse <= 1'b1;
                            cnt_q     <= 25'd0;
                            state_q   <= S_DWELL;
                        end
                    end
                    S_DWELL: begin
                        if (cnt_q == DWELL_LAST) begin
                            if (cur_q == eff_tgt) begin
                                ramp_active <= 1'b0;
                                if (eff_tgt != 12'd0) begin
                                    state_q   <= S_HOLD;
                                    at_target <= 1'b1;
                                end else begin
                                    hven    <= 1'b0;
                                    state_q <= S_IDLE;
                                end
                            end else begin
                                nxt_q   <= step_d;
                                state_q <= S_WRITE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 25'd1;
                        end
                    end
                    S_HOLD: begin
                        if (eff_tgt != cur_q) begin
                            nxt_q       <= step_d;
                            state_q     <= S_WRITE;
                            at_target   <= 1'b0;
                            ramp_active <= 1'b1;
                        end
                    end
                    S_ABORT: begin
                        if (!dac_busy) begin
                            dac_set     <= 12'd0;
                            dac_pulse   <= 1'b1;
                            cur_q       <= 12'd0;
                            hven        <= 1'b0;
                            state_q     <= S_IDLE;
                            ramp_active <= 1'b0;
                        end
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        at_target   <= 1'b0;
                        ramp_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcp_hv_ramp_ctrl.sv
// tb/tb_mcp_hv_ramp_ctrl.sv - self-checking bench for mcp_hv_ramp_ctrl
module tb_mcp_hv_ramp_ctrl;

    localparam int DW = 16;
    localparam int ST = 230;
    localparam int SC = 10;

    logic        clk50 = 1'b0;
    logic        rst_n = 1'b0;
    logic        hven_cmd = 1'b0;
    logic        safe_cmd = 1'b0;
    logic        reset_cmd = 1'b0;
    logic [11:0] target = 12'd0;
    logic        dac_busy = 1'b0;
    logic [11:0] dac_set;
    logic        dac_pulse;
    logic        hven;
    logic        at_target;
    logic        ramp_active;

    always #10 clk50 = ~clk50;

    mcp_hv_ramp_ctrl #(.STEP(ST), .START_CODE(SC), .DWELL_CYCLES(DW)) dut (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .hven_cmd   (hven_cmd),
        .safe_cmd   (safe_cmd),
        .reset_cmd  (reset_cmd),
        .target     (target),
        .dac_busy   (dac_busy),
        .dac_set    (dac_set),
        .dac_pulse  (dac_pulse),
        .hven       (hven),
        .at_target  (at_target),
        .ramp_active(ramp_active)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_pulse_cyc = -100;
    int pulse_count = 0;
    logic [11:0] codes[$];
    int          pcyc[$];
    bit          busy_at_edge;

    // Reference model: phase name plus integer code bookkeeping.
    string m_ph;
    int    m_cur, m_nxt, m_left, m_set;
    bit    m_pulse, m_hven, m_armed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int toward(input int cur, input int tgt);
        if (tgt > cur) return (tgt - cur <= ST) ? tgt : cur + ST;
        if (tgt < cur) return (cur - tgt <= ST) ? tgt : cur - ST;
        return cur;
    endfunction

    task automatic model_reset();
        m_ph = "idle"; m_cur = 0; m_nxt = 0; m_left = 0; m_set = 0;
        m_pulse = 0; m_hven = 0; m_armed = 0;
    endtask

    task automatic model_step();
        int eff;
        bit can_enable;
        if (!rst_n) begin
            model_reset();
            return;
        end
        eff = (safe_cmd || !hven_cmd) ? 0 : int'(target);
        can_enable = m_armed;
        if (!hven_cmd) m_armed = 1;
        m_pulse = 0;
        if (reset_cmd && m_ph != "idle" && m_ph != "abort") begin
            m_ph = "abort";
        end else if (m_ph == "idle") begin
            if (can_enable && hven_cmd && !safe_cmd && !reset_cmd) begin
                m_hven = 1;
                m_nxt = (int'(target) < SC) ? int'(target) : SC;
                m_ph = "write";
            end
        end else if (m_ph == "write") begin
            if (!dac_busy) begin
                m_set = m_nxt; m_cur = m_nxt; m_pulse = 1; m_left = DW; m_ph = "dwell";
            end
        end else if (m_ph == "dwell") begin
            m_left--;
            if (m_left == 0) begin
                if (m_cur == eff) begin
                    if (eff != 0) m_ph = "hold";
                    else begin m_hven = 0; m_ph = "idle"; end
                end else begin
                    m_nxt = toward(m_cur, eff); m_ph = "write";
                end
            end
        end else if (m_ph == "hold") begin
            if (eff != m_cur) begin
                m_nxt = toward(m_cur, eff); m_ph = "write";
            end
        end else if (m_ph == "abort") begin
            if (!dac_busy) begin
                m_set = 0; m_pulse = 1; m_cur = 0; m_hven = 0; m_ph = "idle";
            end
        end
    endtask

    task automatic tick();
        logic [15:0] ev;
        bit m_at, m_ra;
        @(posedge clk50);
        busy_at_edge = dac_busy;
        model_step();
        #1;
        cyc++;
        m_at = (m_ph == "hold");
        m_ra = (m_ph == "write" || m_ph == "dwell" || m_ph == "abort");
        ev = {m_set[11:0], m_pulse, m_hven, m_at, m_ra};
        chk("outputs_vs_model", {dac_set, dac_pulse, hven, at_target, ramp_active}, ev);
        if (dac_pulse === 1'b1) begin
            chk("pulse_not_when_busy", busy_at_edge, 0);
            chk("pulse_not_back_to_back", (cyc - last_pulse_cyc) > 1, 1);
            last_pulse_cyc = cyc;
            pulse_count++;
            codes.push_back(dac_set);
            pcyc.push_back(cyc);
        end
    endtask

    task automatic do_reset();
        dac_busy = 0; reset_cmd = 0; safe_cmd = 0; hven_cmd = 0;
        #3;
        rst_n = 0;
        #1;
        model_reset();
        chk("reset_outputs", {dac_set, dac_pulse, hven, at_target, ramp_active}, 0);
        tick();
        rst_n = 1;
        tick();
        tick();
    endtask

    task automatic wait_pulse(input int budget);
        int n0;
        n0 = pulse_count;
        for (int i = 0; i < budget && pulse_count == n0; i++) tick();
        chk("wait_pulse_in_time", pulse_count > n0, 1);
    endtask

    task automatic ramp_to_hold(input int tgt);
        target = 12'(tgt);
        hven_cmd = 1;
        for (int i = 0; i < 800 && at_target !== 1'b1; i++) tick();
        chk("reach_hold", at_target, 1);
    endtask

    typedef struct {
        int tgt;
        int n_writes;
        int first;
        int last;
    } vec_t;

    vec_t vt[5];

    initial begin
        int bad, n0, t0;
        vt[0] = '{500, 4, 10, 500};
        vt[1] = '{5, 1, 5, 5};
        vt[2] = '{240, 2, 10, 240};
        vt[3] = '{4095, 19, 10, 4095};
        vt[4] = '{2300, 11, 10, 2300};
        model_reset();

        // Table-driven ramps from IDLE.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            codes.delete(); pcyc.delete();
            target = 12'(vt[v].tgt);
            hven_cmd = 1;
            tick();
            chk("enable_hven_latency", hven, 1);
            tick();
            chk("enable_pulse_latency", dac_pulse, 1);
            for (int i = 0; i < 800 && at_target !== 1'b1; i++) tick();
            chk("vec_at_target", at_target, 1);
            chk("vec_hven_on", hven, 1);
            chk("vec_n_writes", codes.size(), vt[v].n_writes);
            if (codes.size() > 0) begin
                chk("vec_first_code", codes[0], vt[v].first);
                chk("vec_last_code", codes[codes.size()-1], vt[v].last);
                chk("vec_hold_delay", cyc - pcyc[pcyc.size()-1], DW);
            end
            bad = 0;
            for (int i = 1; i < pcyc.size(); i++) if (pcyc[i] - pcyc[i-1] != DW + 1) bad++;
            chk("vec_pulse_spacing", bad, 0);
        end

        // Safe ramp-down from HOLD at 2300.
        codes.delete(); pcyc.delete();
        safe_cmd = 1;
        for (int i = 0; i < 400 && hven !== 1'b0; i++) tick();
        chk("safe_n_writes", codes.size(), 10);
        if (codes.size() == 10) begin
            chk("safe_first", codes[0], 2070);
            chk("safe_fifth", codes[4], 1150);
            chk("safe_last", codes[9], 0);
            chk("safe_hven_drop_delay", cyc - pcyc[9], DW);
        end
        chk("safe_idle", {at_target, ramp_active}, 0);
        hven_cmd = 0; tick();
        hven_cmd = 1; n0 = pulse_count;
        for (int i = 0; i < 30; i++) tick();
        chk("safe_blocks_enable", pulse_count - n0, 0);
        chk("safe_blocks_hven", hven, 0);

        // Retarget down from HOLD at 2300.
        do_reset();
        ramp_to_hold(2300);
        codes.delete(); pcyc.delete();
        target = 12'd1900;
        tick();
        for (int i = 0; i < 200 && at_target !== 1'b1; i++) tick();
        chk("retarget_n_writes", codes.size(), 2);
        if (codes.size() == 2) begin
            chk("retarget_c0", codes[0], 2070);
            chk("retarget_c1", codes[1], 1900);
        end
        chk("retarget_hold", at_target, 1);

        // Busy at WRITE entry delays the write by the busy length.
        target = 12'd1000;
        wait_pulse(40);
        t0 = cyc;
        for (int i = 0; i < DW; i++) tick();
        dac_busy = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_no_pulse", dac_pulse, 0);
        end
        dac_busy = 0;
        tick();
        chk("busy_delayed_pulse", dac_pulse, 1);
        chk("busy_delay_cycles", cyc - t0, DW + 1 + 5);

        // Abort mid-dwell at code 930.
        do_reset();
        target = 12'd2300; hven_cmd = 1;
        for (int i = 0; i < 400 && !(dac_pulse === 1'b1 && dac_set == 12'd930); i++) tick();
        chk("abort_reached_930", dac_set, 930);
        for (int i = 0; i < 5; i++) tick();
        reset_cmd = 1;
        tick();
        chk("abort_entered", {dac_pulse, ramp_active}, 2'b01);
        tick();
        chk("abort_pulse", dac_pulse, 1);
        chk("abort_code", dac_set, 0);
        chk("abort_hven", hven, 0);
        n0 = pulse_count;
        for (int i = 0; i < 40; i++) tick();
        chk("abort_no_more_pulses", pulse_count - n0, 0);
        hven_cmd = 0; tick();
        reset_cmd = 0; tick();

        // Abort with DAC busy at ABORT entry.
        hven_cmd = 1; target = 12'd2300;
        wait_pulse(10);
        for (int i = 0; i < 3; i++) tick();
        t0 = cyc;
        reset_cmd = 1;
        tick();
        dac_busy = 1;
        for (int i = 0; i < 5; i++) tick();
        dac_busy = 0;
        tick();
        chk("abort_busy_pulse", dac_pulse, 1);
        chk("abort_busy_delay", cyc - t0, 7);
        hven_cmd = 0; tick();
        reset_cmd = 0; tick();

        // reset_cmd in IDLE does nothing.
        do_reset();
        reset_cmd = 1; n0 = pulse_count;
        for (int i = 0; i < 20; i++) tick();
        chk("reset_in_idle_no_pulse", pulse_count - n0, 0);
        reset_cmd = 0;

        // Async rst_n mid-ramp; no restart until hven_cmd toggles.
        do_reset();
        target = 12'd2300; hven_cmd = 1;
        wait_pulse(10); wait_pulse(40);
        for (int i = 0; i < 4; i++) tick();
        #5;
        rst_n = 0;
        #1;
        model_reset();
        chk("rstn_outputs_clear", {dac_set, dac_pulse, hven, at_target, ramp_active}, 0);
        tick(); tick();
        rst_n = 1;
        n0 = pulse_count;
        for (int i = 0; i < 60; i++) tick();
        chk("rstn_no_restart", pulse_count - n0, 0);
        hven_cmd = 0; tick();
        hven_cmd = 1; tick();
        chk("rstn_reenable", hven, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            dac_busy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) hven_cmd = ~hven_cmd;
            if ($urandom_range(0, 299) == 0) safe_cmd = ~safe_cmd;
            if ($urandom_range(0, 399) == 0) reset_cmd = ~reset_cmd;
            if ($urandom_range(0, 199) == 0) target = 12'($urandom_range(0, 4095));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
